adc_spi_capture: RTL and testbench

//  Serial front end for the dual-channel 14-bit ADC on the shared SPI bus, directly below the amp/ADC

---
 rtl/adc_spi_capture.sv | 184 ++++++++++++++++++
 tb/tb_adc_spi_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: SPI read-out of the dual-channel 14-bit ADC.
// One accepted GO_ADC gives one AD_CONV strobe followed by a 34-SCK read frame.
// Both 14-bit samples are reduced to 8-bit offset binary on ADC0/ADC1, then
// DONE_ADC is raised.
// Optional feature macro: ADC_ROUND_EN selects round-to-nearest with saturation.
// The default build (macro undefined) truncates the samples instead.
module adc_spi_capture #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       GO_ADC,
  input  logic       SPI_MISO,
  output logic       AD_CONV,
  output logic       SPI_SCK,
  output logic       DONE_ADC,
  output logic       BUSY,
  output logic [7:0] ADC0,
  output logic [7:0] ADC1
);

  localparam int DATA_W = 14;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT = 6'd33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [DIV_W-1:0] div_cnt, div_n;
  logic [5:0]       bit_cnt, bit_n;
  logic             sck_q, sck_n;
  logic             conv_q, conv_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;
  logic             capture;
  logic             load_res;
  logic             half_tick;

  logic signed [DATA_W-1:0] sh0, sh1;
  logic [7:0]               adc0_q, adc1_q;

  // Reduce one 14-bit two's complement sample to 8-bit offset binary.
  function automatic logic [7:0] reduce_sample(input logic signed [DATA_W-1:0] s);
    logic [7:0] r;
`ifdef ADC_ROUND_EN
    // Round half-up on bit 5; the top positive code saturates instead of wrapping.
    // A small negative value rounding up to zero is allowed.
    if ((s[13:6] == 8'h7F) && s[5])
      r = 8'h7F;
    else
      r = s[13:6] + {7'd0, s[5]};
`else
    r = s[13:6];
`endif
    return {~r[7], r[6:0]};
  endfunction

`ifndef ADC_ROUND_EN
  // The low six bits of each sample are discarded when truncating.
  logic unused_lsbs;
  assign unused_lsbs = ^{sh0[5:0], sh1[5:0]};
`endif

  assign half_tick = (div_cnt == DIV_LAST);

  // Next-state and control decode; every target defaults to hold.
  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    sck_n    = sck_q;
    conv_n   = conv_q;
    done_n   = done_q;
    busy_n   = busy_q;
    capture  = 1'b0;
    load_res = 1'b0;
    unique case (state)
      IDLE: begin
        div_n = '0;
        bit_n = '0;
        sck_n = 1'b0;
        if (GO_ADC) begin
          busy_n  = 1'b1;
          done_n  = 1'b0;
          conv_n  = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        // bit_cnt counts the two CLK_DIV half periods of the strobe.
        if (half_tick) begin
          div_n = '0;
          if (bit_cnt == 6'd1) begin
            bit_n   = '0;
            conv_n  = 1'b0;
            state_n = SHIFT;
          end else begin
            bit_n = bit_cnt + 6'd1;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (half_tick) begin
          div_n = '0;
          if (!sck_q) begin
            sck_n   = 1'b1;
            capture = 1'b1;
          end else begin
            sck_n = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              bit_n   = '0;
              state_n = FIN;
            end else begin
              bit_n = bit_cnt + 6'd1;
            end
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      FIN: begin
        load_res = 1'b1;
        done_n   = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, strobes and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
      conv_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      adc0_q  <= 8'h80;
      adc1_q  <= 8'h80;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      sck_q   <= sck_n;
      conv_q  <= conv_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      if (load_res) begin
        adc0_q <= reduce_sample(sh0);
        adc1_q <= reduce_sample(sh1);
      end
    end
  end

  // Sample shift registers: MISO enters on the SCK rising edge, MSB first.
  always_ff @(posedge clk) begin
    if (capture) begin
      if ((bit_cnt >= 6'd2) && (bit_cnt <= 6'd15))
        sh0 <= {sh0[DATA_W-2:0], SPI_MISO};
      if ((bit_cnt >= 6'd18) && (bit_cnt <= 6'd31))
        sh1 <= {sh1[DATA_W-2:0], SPI_MISO};
    end
  end

  assign AD_CONV  = conv_q;
  assign SPI_SCK  = sck_q;
  assign DONE_ADC = done_q;
  assign BUSY     = busy_q;
  assign ADC0     = adc0_q;
  assign ADC1     = adc1_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture (CLK_DIV=2) with a behavioural ADC serial model.
module tb_adc_spi_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       GO_ADC = 1'b0;
  logic       SPI_MISO = 1'b0;
  logic       AD_CONV, SPI_SCK, DONE_ADC, BUSY;
  logic [7:0] ADC0, ADC1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] ch0_m = '0;
  logic [13:0] ch1_m = '0;
  int          k_m = 0;

  adc_spi_capture #(.CLK_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .GO_ADC   (GO_ADC),
    .SPI_MISO (SPI_MISO),
    .AD_CONV  (AD_CONV),
    .SPI_SCK  (SPI_SCK),
    .DONE_ADC (DONE_ADC),
    .BUSY     (BUSY),
    .ADC0     (ADC0),
    .ADC1     (ADC1)
  );

  always #5 clk = ~clk;

  // Serial bit k of the ADC frame; ignored slots carry 1 to expose misalignment.
  function automatic logic frame_bit(input int k);
    if (k >= 2 && k <= 15)  return ch0_m[15 - k];
    if (k >= 18 && k <= 31) return ch1_m[31 - k];
    return 1'b1;
  endfunction

  // ADC model: bit 0 presented after the conversion strobe, next bit after each SCK fall.
  always @(posedge AD_CONV) begin
    k_m = 0;
    SPI_MISO = frame_bit(0);
  end

  always @(negedge SPI_SCK) begin
    k_m = k_m + 1;
    SPI_MISO = frame_bit(k_m);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a frame with a one-cycle GO, watch it edge by edge until DONE_ADC.
  task automatic frame(input logic [13:0] c0, input logic [13:0] c1,
                       input bit pulse_mid, input bit hold_go, input bit timing);
    int n, rises, conv_hi, last_rise, first_rise, gap_bad, done_at;
    logic prev_sck;
    ch0_m = c0;
    ch1_m = c1;
    @(negedge clk);
    GO_ADC = 1'b1;
    @(posedge clk);
    n = 0; rises = 0; conv_hi = 0; last_rise = -1; first_rise = -1;
    gap_bad = 0; done_at = -1; prev_sck = 1'b0;
    while (done_at < 0 && n < 400) begin
      @(negedge clk);
      if (AD_CONV) conv_hi++;
      if (SPI_SCK && !prev_sck) begin
        if (last_rise >= 0 && (n - last_rise) != 4) gap_bad++;
        if (first_rise < 0) first_rise = n;
        last_rise = n;
        rises++;
      end
      prev_sck = SPI_SCK;
      if (n == 0 && timing) chk("busy_at_e0", int'(BUSY), 1);
      if (n == 2) chk("done_clr_e2", int'(DONE_ADC), 0);
      if (DONE_ADC) done_at = n;
      GO_ADC = hold_go || (pulse_mid && (n == 10 || n == 60));
      n++;
    end
    chk("done_latency", done_at, 141);
    chk("sck_rises", rises, 34);
    chk("busy_at_done", int'(BUSY), 0);
    if (timing) begin
      chk("conv_high_cycles", conv_hi, 4);
      chk("first_rise", first_rise, 6);
      chk("rise_gap_errors", gap_bad, 0);
    end
  endtask

  // Wait for DONE_ADC with a cycle budget; returns negedges counted.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!DONE_ADC && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] e_a0, e_a1, e_b0, e_b1, e_c0, e_c1, e_d0, e_d1;
`ifdef ADC_ROUND_EN
    e_a0 = 8'hFF; e_a1 = 8'h00;
    e_b0 = 8'h80; e_b1 = 8'h80;
    e_c0 = 8'h81; e_c1 = 8'hC9;
    e_d0 = 8'h2B; e_d1 = 8'hD7;
`else
    e_a0 = 8'hFF; e_a1 = 8'h00;
    e_b0 = 8'h80; e_b1 = 8'h7F;
    e_c0 = 8'h80; e_c1 = 8'hC8;
    e_d0 = 8'h2A; e_d1 = 8'hD6;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_adc0", int'(ADC0), 8'h80);
    chk("rst_adc1", int'(ADC1), 8'h80);
    chk("rst_done", int'(DONE_ADC), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_conv", int'(AD_CONV), 0);
    chk("rst_sck", int'(SPI_SCK), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Timing and full-scale data
    frame(14'h1FFF, 14'h2000, 1'b0, 1'b0, 1'b1);
    chk("a_adc0", int'(ADC0), int'(e_a0));
    chk("a_adc1", int'(ADC1), int'(e_a1));
    repeat (3) @(negedge clk);
    chk("done_level_held", int'(DONE_ADC), 1);

    frame(14'h0000, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    chk("b_adc0", int'(ADC0), int'(e_b0));
    chk("b_adc1", int'(ADC1), int'(e_b1));

    frame(14'h0020, 14'h1234, 1'b0, 1'b0, 1'b0);
    chk("c_adc0", int'(ADC0), int'(e_c0));
    chk("c_adc1", int'(ADC1), int'(e_c1));

    // GO while busy is ignored
    frame(14'h2AAA, 14'h15A5, 1'b1, 1'b0, 1'b1);
    chk("d_adc0", int'(ADC0), int'(e_d0));
    chk("d_adc1", int'(ADC1), int'(e_d1));
    repeat (4) @(negedge clk);
    chk("no_restart_busy", int'(BUSY), 0);

    // GO held through FIN restarts immediately
    frame(14'h1FFF, 14'h2000, 1'b0, 1'b1, 1'b0);
    chk("hold_a_adc0", int'(ADC0), int'(e_a0));
    @(negedge clk);
    chk("b2b_done_drop", int'(DONE_ADC), 0);
    chk("b2b_busy", int'(BUSY), 1);
    GO_ADC = 1'b0;
    ch0_m = 14'h0000;
    ch1_m = 14'h3FFF;
    wait_done(cnt);
    chk("b2b_latency", cnt, 141);
    chk("b2b_adc0", int'(ADC0), int'(e_b0));
    chk("b2b_adc1", int'(ADC1), int'(e_b1));

    // Reset in the middle of a frame (first ch1 bits)
    ch0_m = 14'h0020;
    ch1_m = 14'h1234;
    @(negedge clk);
    GO_ADC = 1'b1;
    @(posedge clk);
    @(negedge clk);
    GO_ADC = 1'b0;
    repeat (86) @(negedge clk);
    chk("mid_bit_index", k_m, 20);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_adc0", int'(ADC0), 8'h80);
    chk("mid_rst_adc1", int'(ADC1), 8'h80);
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_sck", int'(SPI_SCK), 0);
    chk("mid_rst_conv", int'(AD_CONV), 0);
    chk("mid_rst_done", int'(DONE_ADC), 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_rst_adc0_hold", int'(ADC0), 8'h80);
    chk("post_rst_done", int'(DONE_ADC), 0);

    frame(14'h2AAA, 14'h15A5, 1'b0, 1'b0, 1'b1);
    chk("e_adc0", int'(ADC0), int'(e_d0));
    chk("e_adc1", int'(ADC1), int'(e_d1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
